// File: rtl/seq_alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package seq_alu_pkg;

   typedef enum logic [2:0] {
      ALU_FWD  = 3'b000,
      ALU_ADD  = 3'b001,
      ALU_AND  = 3'b010,
      ALU_OR   = 3'b011,
      ALU_MULT = 3'b100,
      ALU_SL   = 3'b101,
      ALU_SRA  = 3'b110,
      ALU_ROR  = 3'b111
   } alu_op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_EXEC = 1'b1
   } state_e;

   function automatic logic is_single_cycle(alu_op_e op);
      return op inside {ALU_FWD, ALU_ADD, ALU_AND, ALU_OR};
   endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bundle between the control unit (master) and the ALU (slave).
interface seq_alu_if #(parameter int WIDTH = 8);
   logic             start;
   logic [2:0]       select;
   logic [WIDTH-1:0] data1;
   logic [WIDTH-1:0] data2;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             negative;
   logic             carry;
   logic             overflow;

   modport master (
      output start, select, data1, data2,
      input  busy, done, result, zero, negative, carry, overflow
   );

   modport slave (
      input  start, select, data1, data2,
      output busy, done, result, zero, negative, carry, overflow
   );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative signed shift-add multiplier: magnitudes are multiplied, sign applied at the end.
module seq_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic             i_step,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_last,
   output logic [WIDTH-1:0] o_result,
   output logic             o_ovf
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic               r_sign;
   logic [CNT_W-1:0]   r_cnt;

   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [2*WIDTH-1:0] w_acc_nxt;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH:0]     w_hi;

   // Negating the most-negative value yields 2^(WIDTH-1), which is the correct unsigned magnitude.
   assign w_a_mag   = i_a[WIDTH-1] ? -i_a : i_a;
   assign w_b_mag   = i_b[WIDTH-1] ? -i_b : i_b;
   assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_prod    = r_sign ? -w_acc_nxt : w_acc_nxt;
   assign w_hi      = w_prod[2*WIDTH-1:WIDTH-1];

   assign o_last   = (r_cnt == CNT_W'(1));
   assign o_result = w_prod[WIDTH-1:0];
   assign o_ovf    = !((&w_hi) || (~|w_hi));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_sign   <= 1'b0;
         r_cnt    <= '0;
      end else if (i_load) begin
         r_acc    <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
         r_mplier <= w_b_mag;
         r_sign   <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
         r_cnt    <= CNT_W'(WIDTH);
      end else if (i_step) begin
         r_acc    <= w_acc_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with single-cycle logic/add ops and multi-cycle multiply and bit-serial shifts.
//  state  | meaning
//  S_IDLE | waiting for start; single-cycle ops complete here
//  S_EXEC | multiply or shift iterating, one step per clock
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   seq_alu_if.slave   io_alu
);
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam int SH_W  = $clog2(WIDTH);

   state_e           r_state, w_state_nxt;
   alu_op_e          r_op, w_op_nxt, w_op_in;
   logic [WIDTH-1:0] r_shv, w_shv_nxt, w_shv_step;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_e;
   logic [WIDTH-1:0] r_result, w_res;
   logic             r_zero, r_neg, r_carry, r_ovf, r_done;
   logic             w_commit, w_carry, w_ovf;
   logic [WIDTH:0]   w_sum;
   logic             w_mul_load, w_mul_step, w_mul_last, w_mul_ovf;
   logic [WIDTH-1:0] w_mul_res;

   function automatic logic [WIDTH-1:0] shift1(alu_op_e op, logic [WIDTH-1:0] v);
      case (op)
         ALU_SL:  return v << 1;
         ALU_SRA: return {v[WIDTH-1], v[WIDTH-1:1]};
         ALU_ROR: return {v[0], v[WIDTH-1:1]};
         default: return v;
      endcase
   endfunction

   seq_multiplier #(.WIDTH(WIDTH)) u_mult (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_load   (w_mul_load),
      .i_step   (w_mul_step),
      .i_a      (io_alu.data1),
      .i_b      (io_alu.data2),
      .o_last   (w_mul_last),
      .o_result (w_mul_res),
      .o_ovf    (w_mul_ovf)
   );

   assign w_op_in    = alu_op_e'(io_alu.select);
   assign w_sum      = {1'b0, io_alu.data1} + {1'b0, io_alu.data2};
   assign w_shv_step = shift1(r_op, r_shv);

   // Shifting past WIDTH is pointless for SL/SRA, so the amount saturates; ROR wraps.
   always_comb begin
      w_e = '0;
      if (w_op_in == ALU_ROR)
         w_e = CNT_W'(io_alu.data2[SH_W-1:0]);
      else if (io_alu.data2 >= WIDTH'(WIDTH))
         w_e = CNT_W'(WIDTH);
      else
         w_e = CNT_W'(io_alu.data2);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_op_nxt    = r_op;
      w_shv_nxt   = r_shv;
      w_cnt_nxt   = r_cnt;
      w_commit    = 1'b0;
      w_res       = r_result;
      w_carry     = 1'b0;
      w_ovf       = 1'b0;
      w_mul_load  = 1'b0;
      w_mul_step  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (io_alu.start) begin
               w_op_nxt = w_op_in;
               if (is_single_cycle(w_op_in)) begin
                  w_commit = 1'b1;
                  case (w_op_in)
                     ALU_ADD: begin
                        w_res   = w_sum[WIDTH-1:0];
                        w_carry = w_sum[WIDTH];
                        w_ovf   = (io_alu.data1[WIDTH-1] == io_alu.data2[WIDTH-1]) &&
                                  (w_sum[WIDTH-1] != io_alu.data1[WIDTH-1]);
                     end
                     ALU_AND: w_res = io_alu.data1 & io_alu.data2;
                     ALU_OR:  w_res = io_alu.data1 | io_alu.data2;
                     default: w_res = io_alu.data1;
                  endcase
               end else if (w_op_in == ALU_MULT) begin
                  w_mul_load  = 1'b1;
                  w_state_nxt = S_EXEC;
               end else if (w_e == '0) begin
                  w_commit = 1'b1;
                  w_res    = io_alu.data1;
               end else begin
                  w_shv_nxt   = io_alu.data1;
                  w_cnt_nxt   = w_e;
                  w_state_nxt = S_EXEC;
               end
            end
         end
         S_EXEC: begin
            if (r_op == ALU_MULT) begin
               w_mul_step = 1'b1;
               if (w_mul_last) begin
                  w_commit    = 1'b1;
                  w_res       = w_mul_res;
                  w_ovf       = w_mul_ovf;
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_shv_nxt = w_shv_step;
               w_cnt_nxt = r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  w_commit    = 1'b1;
                  w_res       = w_shv_step;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_op     <= ALU_FWD;
         r_shv    <= '0;
         r_cnt    <= '0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_zero   <= 1'b1;
         r_neg    <= 1'b0;
         r_carry  <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_op   <= w_op_nxt;
         r_shv  <= w_shv_nxt;
         r_cnt  <= w_cnt_nxt;
         r_done <= w_commit;
         if (w_commit) begin
            r_result <= w_res;
            r_zero   <= (w_res == '0);
            r_neg    <= w_res[WIDTH-1];
            r_carry  <= w_carry;
            r_ovf    <= w_ovf;
         end
      end
   end

   assign io_alu.busy     = (r_state == S_EXEC);
   assign io_alu.done     = r_done;
   assign io_alu.result   = r_result;
   assign io_alu.zero     = r_zero;
   assign io_alu.negative = r_neg;
   assign io_alu.carry    = r_carry;
   assign io_alu.overflow = r_ovf;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at WIDTH=8: vector table plus handshake and reset corner cases.
module tb_seq_alu;
   import seq_alu_pkg::*;

   typedef struct {
      alu_op_e    op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       c;
      logic       v;
      int         lat;
      string      name;
   } vec_t;

   typedef struct {
      logic [7:0] res;
      logic       z;
      logic       n;
      logic       c;
      logic       v;
      int         lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];
   vec_t vecs[$];

   seq_alu_if #(.WIDTH(8)) alu_bus ();

   seq_alu #(.WIDTH(8)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_alu  (alu_bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic exp_t mk_exp(logic [7:0] res, logic c, logic v, int lat);
      exp_t e;
      e.res = res;
      e.z   = (res == 8'h00);
      e.n   = res[7];
      e.c   = c;
      e.v   = v;
      e.lat = lat;
      return e;
   endfunction

   task automatic check_flags(input string nm, input exp_t e);
      chk({nm, "_result"}, 32'(alu_bus.result), 32'(e.res));
      chk({nm, "_zero"},   32'(alu_bus.zero),   32'(e.z));
      chk({nm, "_neg"},    32'(alu_bus.negative), 32'(e.n));
      chk({nm, "_carry"},  32'(alu_bus.carry),  32'(e.c));
      chk({nm, "_ovf"},    32'(alu_bus.overflow), 32'(e.v));
   endtask

   // Drives one request, waits (bounded) for DONE, then compares against the scoreboard head.
   task automatic run_op(input alu_op_e op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] res, input logic c, input logic v,
                         input int lat, input string nm);
      exp_t e;
      int   cyc = 0;
      int   busy_cnt = 0;
      bit   got = 0;
      @(negedge clk);
      alu_bus.start  = 1'b1;
      alu_bus.select = op;
      alu_bus.data1  = a;
      alu_bus.data2  = b;
      sb.push_back(mk_exp(res, c, v, lat));
      while (!got && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 1) begin
            alu_bus.start = 1'b0;
            alu_bus.data1 = 8'($urandom);
            alu_bus.data2 = 8'($urandom);
         end
         if (alu_bus.done) got = 1;
         else if (alu_bus.busy) busy_cnt++;
      end
      if (!got) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_timeout actual=no_done required=done_by_%0d", nm, lat);
         void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         chk({nm, "_latency"}, cyc, e.lat);
         chk({nm, "_busy_cycles"}, busy_cnt, e.lat - 1);
         chk({nm, "_busy_at_done"}, 32'(alu_bus.busy), 32'(0));
         check_flags(nm, e);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      exp_t e;
      int   cyc;
      bit   got;

      vecs.push_back('{ALU_ADD,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1, "add_7f_01"});
      vecs.push_back('{ALU_ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1, "add_ff_01"});
      vecs.push_back('{ALU_ADD,  8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1, "add_80_80"});
      vecs.push_back('{ALU_AND,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1, "and"});
      vecs.push_back('{ALU_OR,   8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1, "or"});
      vecs.push_back('{ALU_FWD,  8'hA5, 8'h11, 8'hA5, 1'b0, 1'b0, 1, "fwd"});
      vecs.push_back('{ALU_MULT, 8'hFD, 8'h05, 8'hF1, 1'b0, 1'b0, 9, "mult_fd_05"});
      vecs.push_back('{ALU_MULT, 8'h10, 8'h10, 8'h00, 1'b0, 1'b1, 9, "mult_10_10"});
      vecs.push_back('{ALU_MULT, 8'h80, 8'hFF, 8'h80, 1'b0, 1'b1, 9, "mult_80_ff"});
      vecs.push_back('{ALU_MULT, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 9, "mult_ff_ff"});
      vecs.push_back('{ALU_SRA,  8'h90, 8'h03, 8'hF2, 1'b0, 1'b0, 4, "sra_90_3"});
      vecs.push_back('{ALU_SRA,  8'h80, 8'h09, 8'hFF, 1'b0, 1'b0, 9, "sra_80_9"});
      vecs.push_back('{ALU_ROR,  8'h81, 8'h09, 8'hC0, 1'b0, 1'b0, 2, "ror_81_9"});
      vecs.push_back('{ALU_ROR,  8'h81, 8'h08, 8'h81, 1'b0, 1'b0, 1, "ror_81_8"});
      vecs.push_back('{ALU_SL,   8'h01, 8'd200, 8'h00, 1'b0, 1'b0, 9, "sl_01_200"});
      vecs.push_back('{ALU_SL,   8'h33, 8'h00, 8'h33, 1'b0, 1'b0, 1, "sl_33_0"});
      vecs.push_back('{ALU_SL,   8'h33, 8'h02, 8'hCC, 1'b0, 1'b0, 3, "sl_33_2"});

      rst_n          = 1'b0;
      alu_bus.start  = 1'b0;
      alu_bus.select = 3'b000;
      alu_bus.data1  = 8'h00;
      alu_bus.data2  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", 32'(alu_bus.busy), 32'(0));
      chk("reset_done", 32'(alu_bus.done), 32'(0));
      check_flags("reset", mk_exp(8'h00, 1'b0, 1'b0, 0));
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++)
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                vecs[i].c, vecs[i].v, vecs[i].lat, vecs[i].name);

      // FWD with START held: a completion every cycle.
      @(negedge clk);
      alu_bus.start  = 1'b1;
      alu_bus.select = ALU_FWD;
      alu_bus.data1  = 8'h5A;
      for (int k = 0; k < 3; k++) sb.push_back(mk_exp(8'h5A, 1'b0, 1'b0, 1));
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         e = sb.pop_front();
         chk("held_fwd_done", 32'(alu_bus.done), 32'(1));
         chk("held_fwd_busy", 32'(alu_bus.busy), 32'(0));
         chk("held_fwd_result", 32'(alu_bus.result), 32'(e.res));
      end
      alu_bus.start = 1'b0;
      @(posedge clk);
      #1;
      chk("held_fwd_done_drop", 32'(alu_bus.done), 32'(0));

      // START while busy must be dropped, not queued.
      @(negedge clk);
      alu_bus.start  = 1'b1;
      alu_bus.select = ALU_MULT;
      alu_bus.data1  = 8'h07;
      alu_bus.data2  = 8'h06;
      sb.push_back(mk_exp(8'h2A, 1'b0, 1'b0, 9));
      cyc = 0;
      got = 0;
      while (!got && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
         alu_bus.start = 1'b0;
         if (cyc == 2) begin
            alu_bus.start  = 1'b1;
            alu_bus.select = ALU_ADD;
            alu_bus.data1  = 8'h01;
            alu_bus.data2  = 8'h01;
         end
         if (alu_bus.done) got = 1;
      end
      alu_bus.start = 1'b0;
      e = sb.pop_front();
      chk("ignored_start_got_done", 32'(got), 32'(1));
      chk("ignored_start_latency", cyc, e.lat);
      check_flags("ignored_start", e);
      @(posedge clk);
      #1;
      chk("ignored_start_no_extra_done", 32'(alu_bus.done), 32'(0));
      chk("ignored_start_result_held", 32'(alu_bus.result), 32'(e.res));

      // Asynchronous reset partway through a multiply.
      @(negedge clk);
      alu_bus.start  = 1'b1;
      alu_bus.select = ALU_MULT;
      alu_bus.data1  = 8'h09;
      alu_bus.data2  = 8'h0B;
      @(posedge clk);
      #1;
      alu_bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("midop_busy_before_reset", 32'(alu_bus.busy), 32'(1));
      rst_n = 1'b0;
      #1;
      chk("midop_reset_busy", 32'(alu_bus.busy), 32'(0));
      chk("midop_reset_done", 32'(alu_bus.done), 32'(0));
      check_flags("midop_reset", mk_exp(8'h00, 1'b0, 1'b0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      run_op(ALU_ADD, 8'h02, 8'h03, 8'h05, 1'b0, 1'b0, 1, "post_reset_add");
      @(posedge clk);
      #1;
      chk("post_reset_no_stale_done", 32'(alu_bus.done), 32'(0));

      chk("scoreboard_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
